cipher_session_ctrl: RTL and testbench
======================================

Name: cipher_session_ctrl

Overview:
- Sequences one keyed XOR cipher session: latches a key and a byte count, loads the keystream LFSR, then streams bytes through the XOR with valid/ready handshakes on both sides.
- Sits between a byte source/sink and the keystream generator. Advances the keystream exactly once per accepted byte, so stalls never desynchronise encoder and decoder.
- Frames the session: marks the last output byte, then pulses done.

Parameters:
- LEN_W, 16, width of session byte count; max session length 2^LEN_W-1 bytes

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  session request; sampled only in IDLE
- key  in  8  session key; latched on accepted start
- len  in  LEN_W  session byte count; latched on accepted start
- abort  in  1  cancel the current session
- busy  out  1  high in LOAD, RUN, FLUSH
- done  out  1  one-cycle pulse at normal session end
- aborted  out  1  one-cycle pulse when abort takes effect
- ks_load  out  1  load strobe to keystream generator
- ks_key  out  8  latched key to keystream generator
- ks_step  out  1  advance keystream; high on each accepted input byte
- ks_byte  in  8  current keystream byte from generator
- in_data  in  8  plaintext or ciphertext byte
- in_valid  in  1  source has a byte
- in_ready  out  1  controller accepts a byte
- out_data  out  8  in_data XOR ks_byte, registered
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts a byte
- out_last  out  1  high with the final byte of the session

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, aborted, ks_load, ks_step, in_ready, out_valid, out_last = 0; out_data, ks_key, byte counter = 0.
- FSM states: IDLE, LOAD, RUN, FLUSH.
- IDLE:
  - start=1 and len!=0: latch key and len, go to LOAD.
  - start=1 and len=0: stay in IDLE, pulse done next cycle, no ks_load.
- LOAD: ks_load=1 for exactly one cycle, with ks_key = latched key. Next state is RUN.
- RUN:
  - in_ready = !out_valid | out_ready (single output register, no bubble).
  - Accept: in_valid & in_ready. On accept:
    - ks_step=1 in the same cycle.
    - out_data <= in_data ^ ks_byte; out_valid <= 1.
    - Counter decrements.
    - out_last <= (counter==1).
  - Latency: accepted byte appears on out_data one cycle later.
  - Accepting the final byte moves to FLUSH.
- Output register:
  - out_valid clears when out_ready=1 and no new accept occurs in that cycle.
  - out_data, out_last, out_valid are held stable while out_valid & !out_ready.
- FLUSH: in_ready=0. When the final byte handshakes (out_valid & out_ready), go to IDLE and pulse done in the next cycle.
- ks_step is never asserted outside an accepted-byte cycle; ks_load is never asserted outside LOAD.
- start is ignored while busy.
- abort=1 in LOAD, RUN or FLUSH:
  - Next cycle: state=IDLE, out_valid=0, out_last=0, counter=0.
  - aborted pulses; done does not pulse.
  - Abort takes priority over an accept in the same cycle: no ks_step, and the byte is not consumed.
- abort in IDLE: no effect.
- Counter is LEN_W bits; no wrap is possible because len=0 is not started.
- Reset mid-session: returns immediately to reset values, with no done or aborted pulse.

Optional Feature:
- Macro: CIPHER_STATS_EN.
- Defined:
  - Adds output port byte_total (32 bits): count of bytes handshaken on the output since reset.
  - Wraps at 2^32. Cleared only by reset; unaffected by abort.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic: key=0x5A, len=3, ks_byte held 0xA5, in_data 0x3C, 0x00, 0xFF, out_ready=1 -> ks_load high for 1 cycle in LOAD; out_data 0x99, 0xA5, 0x5A; out_last only on 0x5A; done pulses once; exactly 3 ks_step pulses.
- Backpressure: len=4, out_ready low for 3 cycles after the first output -> out_data held stable; in_ready=0 while stalled; no extra ks_step; all 4 bytes delivered in order.
- Zero length: start with len=0 -> busy stays 0, done pulses once, no ks_load, no ks_step.
- Abort: len=8, assert abort after 2 bytes accepted -> aborted pulses, no done, out_valid=0 next cycle, ks_step count=2; start accepted again afterwards.
- Async reset mid-RUN: drive reset=0 between clock edges -> all outputs zero immediately, state IDLE, no done.
- CIPHER_STATS_EN: two sessions of len 3 and 5 -> byte_total=8; an aborted session adds only the bytes actually handshaken on the output.

Source files
------------

// File: rtl/cipher_session_ctrl.sv
// cipher_session_ctrl: runs one keyed XOR cipher session.
//   Latches key/len on start, pulses ks_load to seed the keystream generator,
//   then streams bytes in_data -> out_data (XOR ks_byte) through a single
//   registered output stage. The keystream advances only on accepted bytes,
//   so stalls on either side keep encoder and decoder in lock-step.
// Optional: define CIPHER_STATS_EN to add byte_total (output handshakes since reset).
// Ports:
//   clk, reset (async, active low)
//   start/key/len/abort          session control
//   busy/done/aborted            session status
//   ks_load/ks_key/ks_step/ks_byte  keystream generator interface
//   in_data/in_valid/in_ready    byte source
//   out_data/out_valid/out_ready/out_last  byte sink
module cipher_session_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       key,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             ks_load,
  output logic [7:0]       ks_key,
  output logic             ks_step,
  input  logic [7:0]       ks_byte,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef CIPHER_STATS_EN
  ,
  output logic [31:0]      byte_total
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             accept;
  logic             out_hs;
  logic             abort_act;

  assign out_hs    = out_valid & out_ready;
  assign abort_act = abort & (state != IDLE);
  assign ks_step   = accept;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ks_load   = 1'b0;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        ks_load   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Abort wins over a same-cycle byte, so ready drops with it: the
        // source must not see a handshake for a byte that is not consumed.
        in_ready = (!out_valid || out_ready) && !abort;
        accept   = in_valid && in_ready;
        if (accept && (cnt == LEN_W'(1))) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ks_key    <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE && start) begin
        if (len != '0) begin
          ks_key <= key;
          cnt    <= len;
        end else begin
          done <= 1'b1;  // empty session completes without touching the keystream
        end
      end
      if (abort_act) begin
        aborted   <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        cnt       <= '0;
      end else begin
        if (accept) begin
          out_data  <= in_data ^ ks_byte;
          out_valid <= 1'b1;
          out_last  <= (cnt == LEN_W'(1));
          cnt       <= cnt - LEN_W'(1);
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        if (state == FLUSH && out_hs) done <= 1'b1;
      end
    end
  end

`ifdef CIPHER_STATS_EN
  // Counts every output handshake, including one landing in an abort cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) byte_total <= '0;
    else if (out_hs) byte_total <= byte_total + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cipher_session_ctrl.sv
// Directed bench for cipher_session_ctrl: basic stream, backpressure,
// zero length, abort, async reset mid-run, and optional byte_total.
module tb_cipher_session_ctrl;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       key = '0;
  logic [LEN_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic             busy, done, aborted, ks_load, ks_step;
  logic [7:0]       ks_key;
  logic [7:0]       ks_byte = 8'hA5;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
`ifdef CIPHER_STATS_EN
  logic [31:0]      byte_total;
`endif

  cipher_session_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .len(len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .ks_load(ks_load), .ks_key(ks_key),
    .ks_step(ks_step), .ks_byte(ks_byte), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
`ifdef CIPHER_STATS_EN
    , .byte_total(byte_total)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: counts strobes and records output bytes.
  int         n_step = 0, n_load = 0, n_done = 0, n_abt = 0, n_hs = 0, n_stall = 0;
  logic [7:0] load_key = '0;
  logic [8:0] oq[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (ks_step) n_step++;
      if (ks_load) begin n_load++; load_key = ks_key; end
      if (done) n_done++;
      if (aborted) n_abt++;
      if (out_valid && out_ready) begin n_hs++; oq.push_back({out_last, out_data}); end
      if (prev_stall) chk("hold", {30'd0, out_valid, out_last, out_data} >> 0, {22'd0, prev_out});
      if (out_valid && !out_ready) begin
        n_stall++;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_last, out_data};
    end
  end

  int s_step, s_load, s_done, s_abt, s_hs, s_stall, s_q;
  task automatic snap();
    s_step = n_step; s_load = n_load; s_done = n_done; s_abt = n_abt;
    s_hs = n_hs; s_stall = n_stall; s_q = oq.size();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [7:0] src[8];

  // Runs one session; stall_cycles drops out_ready after the first output,
  // abort_after asserts abort once that many bytes have been accepted.
  task automatic session(input logic [7:0] k, input int n, input int stall_cycles, input int abort_after);
    int idx = 0, stall = 0, cyc = 0;
    bit first_seen = 0, acc, hs;
    start = 1'b1; key = k; len = LEN_W'(n);
    tick();
    start = 1'b0;
    while (1) begin
      in_valid  = (idx < n);
      in_data   = src[idx % 8];
      out_ready = (stall == 0);
      abort     = (abort_after >= 0) && (idx == abort_after);
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      tick();
      if (acc) idx++;
      if (stall > 0) stall--;
      else if (hs && !first_seen) begin first_seen = 1; stall = stall_cycles; end
      abort = 1'b0;
      if (!busy) break;
      cyc++;
      if (cyc > 100) begin chk("timeout", 32'd1, 32'd0); break; end
    end
    in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ctl", {24'd0, busy, done, aborted, ks_load, ks_step, in_ready, out_valid, out_last}, 32'd0);
    chk("rst_data", {16'd0, out_data, ks_key}, 32'd0);
    #11 reset = 1'b1;
    tick();

    // Basic session
    src[0] = 8'h3C; src[1] = 8'h00; src[2] = 8'hFF;
    snap();
    session(8'h5A, 3, 0, -1);
    tick(); tick();
    chk("basic_loads", n_load - s_load, 1);
    chk("basic_key", {24'd0, load_key}, 32'h5A);
    chk("basic_steps", n_step - s_step, 3);
    chk("basic_done", n_done - s_done, 1);
    chk("basic_nout", oq.size() - s_q, 3);
    chk("basic_o0", {23'd0, oq[s_q]}, {23'd0, 9'h099});
    chk("basic_o1", {23'd0, oq[s_q+1]}, {23'd0, 9'h0A5});
    chk("basic_o2", {23'd0, oq[s_q+2]}, {23'd0, 9'h15A});

    // Backpressure
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    snap();
    session(8'h3C, 4, 3, -1);
    tick(); tick();
    chk("bp_stalls", n_stall - s_stall, 3);
    chk("bp_steps", n_step - s_step, 4);
    chk("bp_done", n_done - s_done, 1);
    chk("bp_nout", oq.size() - s_q, 4);
    chk("bp_o0", {23'd0, oq[s_q]}, {23'd0, 9'h0B4});
    chk("bp_o1", {23'd0, oq[s_q+1]}, {23'd0, 9'h087});
    chk("bp_o2", {23'd0, oq[s_q+2]}, {23'd0, 9'h096});
    chk("bp_o3", {23'd0, oq[s_q+3]}, {23'd0, 9'h1E1});

    // Zero length
    snap();
    start = 1'b1; len = '0; key = 8'hEE;
    tick();
    start = 1'b0;
    chk("zl_done", {31'd0, done}, 32'd1);
    chk("zl_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("zl_done_clr", {31'd0, done}, 32'd0);
    tick();
    chk("zl_loads", n_load - s_load, 0);
    chk("zl_steps", n_step - s_step, 0);
    chk("zl_dones", n_done - s_done, 1);

    // Abort in IDLE does nothing
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort", {30'd0, busy, aborted}, 32'd0);

    // Abort after two accepted bytes
    for (int i = 0; i < 8; i++) src[i] = 8'(i * 16 + 1);
    snap();
    session(8'h77, 8, 0, 2);
    chk("ab_pulse", {31'd0, aborted}, 32'd1);
    chk("ab_ov", {30'd0, out_valid, out_last}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ab_clr", {31'd0, aborted}, 32'd0);
    tick();
    chk("ab_steps", n_step - s_step, 2);
    chk("ab_dones", n_done - s_done, 0);
    chk("ab_aborts", n_abt - s_abt, 1);

    // Start accepted again after abort
    src[0] = 8'h01;
    snap();
    session(8'h10, 1, 0, -1);
    tick(); tick();
    chk("re_loads", n_load - s_load, 1);
    chk("re_done", n_done - s_done, 1);
    chk("re_o0", {23'd0, oq[s_q]}, {23'd0, 9'h1A4});

    // Async reset mid-RUN
    snap();
    start = 1'b1; key = 8'h66; len = LEN_W'(4);
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h12;
    tick();
    tick();
    chk("mr_pre", {30'd0, busy, out_valid}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("mr_ctl", {24'd0, busy, done, aborted, ks_load, ks_step, in_ready, out_valid, out_last}, 32'd0);
    chk("mr_data", {16'd0, out_data, ks_key}, 32'd0);
    #3 reset = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mr_idle", {30'd0, busy, done}, 32'd0);
    chk("mr_dones", n_done - s_done, 0);
    chk("mr_aborts", n_abt - s_abt, 0);

    // Output handshake totals
`ifdef CIPHER_STATS_EN
    chk("st_zero", byte_total, 32'd0);
`endif
    session(8'h21, 3, 0, -1);
    session(8'h42, 5, 0, -1);
    tick(); tick();
`ifdef CIPHER_STATS_EN
    chk("st_eight", byte_total, 32'd8);
`endif
    snap();
    session(8'h99, 8, 0, 2);
    tick(); tick();
    chk("st_ab_hs", n_hs - s_hs, 2);
`ifdef CIPHER_STATS_EN
    chk("st_ten", byte_total, 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
